// File: rtl/hazard_ctrl_param.sv
// rtl/hazard_ctrl_param.sv - parametrised pipeline stall/flush controller with multi-cycle busy and stall counters
module hazard_ctrl_param #(
    parameter int STAGES = 5,
    parameter int AW     = 4,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hit,
    input  logic              d_hit,
    input  logic              mem_op,
    input  logic              mem_re_ex,
    input  logic              mem_we_id,
    input  logic [AW-1:0]     dst_addr,
    input  logic [AW-1:0]     p0_addr,
    input  logic [AW-1:0]     p1_addr,
    input  logic              p0_used,
    input  logic              p1_used,
    input  logic              send,
    input  logic              full,
    input  logic              branch_taken,
    input  logic              md_start,
    input  logic              clr_cnt,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MDW = $clog2(MD_LAT) + 1;
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LAT - 1);

    logic           miss;
    logic           load_use;
    logic [MDW-1:0] md_cnt;

    assign miss     = ~i_hit | (mem_op & ~d_hit);
    assign load_use = mem_re_ex & ~mem_we_id &
                      ((p0_used & (dst_addr == p0_addr)) |
                       (p1_used & (dst_addr == p1_addr)));
    assign md_busy  = (md_cnt != '0);

    // Priority chain: miss freezes everything, then EX occupancy, branch squash,
    // load-use bubble and finally SPART backpressure.
    always_comb begin
        stall = '0;
        flush = '0;
        if (miss) begin
            stall = '1;
        end else if (md_busy) begin
            stall[2:0] = 3'b111;
            flush[3]   = 1'b1;
        end else if (branch_taken) begin
            flush[2:1] = 2'b11;
        end else if (load_use) begin
            stall[1:0] = 2'b11;
            flush[2]   = 1'b1;
        end else if (send & full) begin
            stall[2:0] = 3'b111;
        end
    end

    // A held md_start during busy is the same instruction, so it never reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt <= '0;
        end else if (!miss) begin
            if (md_busy)
                md_cnt <= md_cnt - 1'b1;
            else if (md_start)
                md_cnt <= MD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (clr_cnt)
            stall_cnt <= '0;
        else if (stall[0] && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb/tb_hazard_ctrl_param.sv - scoreboard testbench for hazard_ctrl_param
module tb_hazard_ctrl_param;

    localparam int STAGES = 5;
    localparam int AW     = 4;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_hit, d_hit, mem_op, mem_re_ex, mem_we_id;
    logic [AW-1:0]     dst_addr, p0_addr, p1_addr;
    logic              p0_used, p1_used, send, full, branch_taken, md_start, clr_cnt;
    logic [STAGES-1:0] stall, flush;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    typedef struct {
        string             name;
        logic [STAGES-1:0] st;
        logic [STAGES-1:0] fl;
        logic              busy;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    hazard_ctrl_param #(
        .STAGES(STAGES), .AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .i_hit(i_hit), .d_hit(d_hit), .mem_op(mem_op),
        .mem_re_ex(mem_re_ex), .mem_we_id(mem_we_id), .dst_addr(dst_addr),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_used(p0_used), .p1_used(p1_used),
        .send(send), .full(full), .branch_taken(branch_taken), .md_start(md_start),
        .clr_cnt(clr_cnt), .stall(stall), .flush(flush), .md_busy(md_busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL %s stall got %b exp %b", e.name, stall, e.st);
            end
            if (flush !== e.fl) begin
                errors++;
                $display("FAIL %s flush got %b exp %b", e.name, flush, e.fl);
            end
            if (md_busy !== e.busy) begin
                errors++;
                $display("FAIL %s md_busy got %b exp %b", e.name, md_busy, e.busy);
            end
            if (stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d exp %0d", e.name, stall_cnt, e.cnt);
            end
        end
    end

    task automatic idle_inputs();
        i_hit = 1'b1; d_hit = 1'b1; mem_op = 1'b0; mem_re_ex = 1'b0; mem_we_id = 1'b0;
        dst_addr = '0; p0_addr = 4'h1; p1_addr = 4'h2; p0_used = 1'b0; p1_used = 1'b0;
        send = 1'b0; full = 1'b0; branch_taken = 1'b0; md_start = 1'b0; clr_cnt = 1'b0;
    endtask

    // Issue one cycle of the currently driven inputs with hand-computed stall/flush/busy.
    task automatic cyc(input string nm, input logic [STAGES-1:0] es,
                       input logic [STAGES-1:0] ef, input logic eb);
        exp_t e;
        e.name = nm; e.st = es; e.fl = ef; e.busy = eb; e.cnt = model_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (clr_cnt)
            model_cnt = '0;
        else if (es[0] && model_cnt != '1)
            model_cnt = model_cnt + 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cyc("reset_idle", 5'b00000, 5'b00000, 1'b0);

        i_hit = 1'b0;
        for (int i = 0; i < 3; i++) cyc("imiss", 5'b11111, 5'b00000, 1'b0);
        i_hit = 1'b1;
        cyc("after_miss", 5'b00000, 5'b00000, 1'b0);
        mem_op = 1'b1; d_hit = 1'b0;
        cyc("dmiss", 5'b11111, 5'b00000, 1'b0);
        d_hit = 1'b1;
        cyc("dhit_memop", 5'b00000, 5'b00000, 1'b0);
        mem_op = 1'b0;

        mem_re_ex = 1'b1; dst_addr = 4'h5; p1_addr = 4'h5; p1_used = 1'b1;
        cyc("loaduse_p1", 5'b00011, 5'b00100, 1'b0);
        p1_used = 1'b0;
        cyc("loaduse_unused", 5'b00000, 5'b00000, 1'b0);
        p0_addr = 4'h5; p0_used = 1'b1;
        cyc("loaduse_p0", 5'b00011, 5'b00100, 1'b0);
        mem_we_id = 1'b1;
        cyc("loaduse_store", 5'b00000, 5'b00000, 1'b0);
        mem_we_id = 1'b0; p0_addr = 4'h6;
        cyc("loaduse_nomatch", 5'b00000, 5'b00000, 1'b0);

        p1_used = 1'b1; send = 1'b1; full = 1'b1; branch_taken = 1'b1;
        cyc("branch_wins", 5'b00000, 5'b00110, 1'b0);
        idle_inputs();

        send = 1'b1; full = 1'b1;
        cyc("spart_full0", 5'b00111, 5'b00000, 1'b0);
        cyc("spart_full1", 5'b00111, 5'b00000, 1'b0);
        full = 1'b0;
        cyc("spart_free", 5'b00000, 5'b00000, 1'b0);
        idle_inputs();

        md_start = 1'b1;
        cyc("md_start", 5'b00000, 5'b00000, 1'b0);
        md_start = 1'b0;
        for (int i = 0; i < 3; i++) cyc("md_busy", 5'b00111, 5'b01000, 1'b1);
        cyc("md_done", 5'b00000, 5'b00000, 1'b0);

        md_start = 1'b1;
        cyc("md2_start", 5'b00000, 5'b00000, 1'b0);
        md_start = 1'b0;
        cyc("md2_b1", 5'b00111, 5'b01000, 1'b1);
        i_hit = 1'b0;
        cyc("md2_b2_miss", 5'b11111, 5'b00000, 1'b1);
        i_hit = 1'b1; branch_taken = 1'b1;
        cyc("md2_b3_branch", 5'b00111, 5'b01000, 1'b1);
        branch_taken = 1'b0;
        cyc("md2_b4", 5'b00111, 5'b01000, 1'b1);
        cyc("md2_done", 5'b00000, 5'b00000, 1'b0);

        md_start = 1'b1;
        cyc("md3_start", 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 3; i++) cyc("md3_held", 5'b00111, 5'b01000, 1'b1);
        md_start = 1'b0;
        cyc("md3_done", 5'b00000, 5'b00000, 1'b0);

        md_start = 1'b1; i_hit = 1'b0;
        cyc("md_start_miss", 5'b11111, 5'b00000, 1'b0);
        md_start = 1'b0; i_hit = 1'b1;
        cyc("md_not_loaded", 5'b00000, 5'b00000, 1'b0);

        clr_cnt = 1'b1;
        cyc("clr", 5'b00000, 5'b00000, 1'b0);
        clr_cnt = 1'b0;
        i_hit = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) cyc("sat_run", 5'b11111, 5'b00000, 1'b0);
        i_hit = 1'b1;
        cyc("sat_hold", 5'b00000, 5'b00000, 1'b0);
        i_hit = 1'b0; clr_cnt = 1'b1;
        cyc("clr_over_stall", 5'b11111, 5'b00000, 1'b0);
        i_hit = 1'b1; clr_cnt = 1'b0;
        cyc("after_clr", 5'b00000, 5'b00000, 1'b0);

        send = 1'b1; full = 1'b1;
        cyc("pre_rst_stall", 5'b00111, 5'b00000, 1'b0);
        idle_inputs();
        md_start = 1'b1;
        cyc("rst_md_start", 5'b00000, 5'b00000, 1'b0);
        md_start = 1'b0;
        cyc("rst_md_b1", 5'b00111, 5'b01000, 1'b1);
        rst = 1'b1;
        model_cnt = '0;
        cyc("rst_mid_op", 5'b00000, 5'b00000, 1'b0);
        rst = 1'b0;
        model_cnt = '0;
        cyc("post_rst", 5'b00000, 5'b00000, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
